dec_to_bcd_key_encoder: RTL and testbench
=========================================

Name: dec_to_bcd_key_encoder

Overview:
- Sequential decimal-to-BCD encoder for a 10-key decimal keypad; the inverse direction of the BCD-to-decimal one-hot decoder.
- Samples a 10-line one-hot key bus and debounces it. Each accepted key press is encoded to a 4-bit BCD digit and shifted into a multi-digit BCD entry register.
- Sits between the keypad inputs and the BCD display and decode path.

Parameters:
- DIGITS, 4, number of BCD digits held in Entry; legal range 1..15.
- DEB_CYCLES, 4, number of consecutive identical samples required to accept a press or a release; legal range 2..255.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- DECIn  in  10  key lines, active-high. Bit i set means key i is pressed.
- Clear  in  1  synchronous clear of Entry and Count.
- BCDOut  out  4  last accepted digit, 0..9.
- Valid  out  1  one-cycle pulse when a digit is accepted.
- Err  out  1  one-cycle pulse on a rejected press.
- Entry  out  4*DIGITS  packed BCD entry; newest digit in [3:0].
- Count  out  4  number of digits entered, saturating at DIGITS.

Behaviour:
- Reset: RST high asynchronously forces state IDLE, debounce counter 0, sample register 0, BCDOut 0, Valid 0, Err 0, Entry 0, Count 0. Reset mid-debounce or mid-hold discards the press in progress.
- Sampling: DECIn is registered every edge into samp. A debounce counter counts consecutive edges where DECIn equals samp. A mismatch reloads samp and resets the counter to 1.
- IDLE: stays while samp==0. A nonzero sample moves to DEB.
- DEB:
  - A zero sample returns to IDLE with no output.
  - A changed nonzero sample restarts the count with the new code.
  - When DEB_CYCLES consecutive identical nonzero samples are reached, the code is evaluated and the block moves to HELD.
  - Exactly one bit set: accept. Multiple bits set: reject.
- Timing: DECIn changes after edge 0 and is stable. With DEB_CYCLES=4, Valid or Err is high from edge 4 to edge 5.
- Accept:
  - BCDOut is set to the index of the set bit (bit0 gives 0, bit9 gives 9).
  - Valid pulses for one cycle.
  - Entry is updated as {Entry[4*DIGITS-5:0], digit}.
  - Count increments, saturating at DIGITS. Once full, the oldest digit is discarded.
- Reject: Err pulses for one cycle. BCDOut, Entry and Count are unchanged.
- HELD: waits for release. Any other key pattern is ignored (no rollover). A zero sample moves to REL.
- REL:
  - DEB_CYCLES consecutive zero samples return to IDLE.
  - Any nonzero sample returns to HELD and generates no new digit, so bounce on release is suppressed.
- Clear:
  - Zeroes Entry and Count on the next edge. BCDOut is retained.
  - Clear has priority over an accept in the same cycle: the digit is discarded and Valid stays 0.
  - Clear does not change FSM state.
- Valid and Err are never high in the same cycle. Both are registered outputs.

Optional Feature:
- Macro: KEY_LOCK_EN.
- Defined: when Count==DIGITS, an otherwise valid press is rejected. Err pulses, Valid stays 0, and Entry and Count are frozen until Clear.
- Undefined: a full Entry shifts and discards its oldest digit, as described under Accept.

Test Plan:
- Reset: RST=1 with DECIn=10'h004 → all outputs 0. Release RST and hold DECIn=10'h004 for 6 edges → Valid pulses once at the 4th sample, BCDOut=2, Entry=16'h0002, Count=1.
- Bounce: DECIn alternates 10'h008/0 every edge for 6 edges, then holds 10'h008 → a single Valid after 4 stable samples, BCDOut=3. Release with 1-cycle bounces → no second Valid.
- Multi-key: DECIn=10'h201 stable → Err pulses, Valid=0, Entry and Count unchanged. Then release → return to IDLE.
- Entry: press and release keys 1,2,3,4,5 → Entry=16'h2345, Count=4. With KEY_LOCK_EN: Entry=16'h1234, and the 5th press gives Err.
- Clear collision: assert Clear on the same cycle as an accept of key 7 → Valid=0, Entry=0, Count=0, BCDOut keeps its previous value.
- Async reset during HELD with key 9 pressed → immediate zeros. Keeping DECIn=10'h200 after reset → a fresh press is accepted after 4 samples.

Source files
------------

// File: rtl/dec_to_bcd_key_encoder_if.sv
// Keypad-side bundle for the decimal-to-BCD key encoder.
// Latency: none; this is only a bundle of wires.
// Backpressure: none; the encoder never stalls the keypad.
interface dec_to_bcd_key_encoder_if #(
  parameter int DIGITS = 4
);
  logic [9:0]          DECIn;
  logic                Clear;
  logic [3:0]          BCDOut;
  logic                Valid;
  logic                Err;
  logic [4*DIGITS-1:0] Entry;
  logic [3:0]          Count;

  // Keypad / test side drives key lines and clear, observes results.
  modport master (
    output DECIn, Clear,
    input  BCDOut, Valid, Err, Entry, Count
  );

  // Encoder side.
  modport slave (
    input  DECIn, Clear,
    output BCDOut, Valid, Err, Entry, Count
  );
endinterface

// File: rtl/dec_to_bcd_key_encoder.sv
// Debounced 10-key one-hot keypad to BCD digit encoder with a shifting entry register.
// Latency: Valid/Err pulse DEB_CYCLES edges after a stable press first appears.
// Backpressure: none; presses are sampled every edge. Optional KEY_LOCK_EN macro freezes a full entry.
module dec_to_bcd_key_encoder #(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 4
) (
  input logic                   CLK,
  input logic                   RST,
  dec_to_bcd_key_encoder_if.slave bus
);

  localparam int         ENTRY_W = 4 * DIGITS;
  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);
  localparam logic [3:0] FULL    = 4'(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    HELD,
    REL
  } state_t;

  state_t       state;
  logic [9:0]   samp;
  logic [7:0]   cnt;

  logic [7:0]   cnt_nxt;
  logic         reached;
  logic         one_hot;
  logic         any_key;
  logic [3:0]   digit;
  logic         full;
  logic         locked;
  logic [ENTRY_W-1:0] entry_shift;

  // Run length of the current sample value, saturating so it never wraps while a key is held.
  always_comb begin
    cnt_nxt = 8'd1;
    if (bus.DECIn == samp) begin
      cnt_nxt = (cnt >= DEB_MAX) ? DEB_MAX : cnt + 8'd1;
    end
    reached = (cnt_nxt == DEB_MAX);
  end

  // Key index encoding and the shifted entry value for an accepted digit.
  always_comb begin
    digit   = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.DECIn[i]) digit = 4'(i);
    end
    one_hot = $onehot(bus.DECIn);
    any_key = |bus.DECIn;
    full    = (bus.Count == FULL);
`ifdef KEY_LOCK_EN
    locked  = full;
`else
    locked  = 1'b0;
`endif
    // Shift-then-overwrite keeps this legal for a single-digit entry.
    entry_shift       = bus.Entry << 4;
    entry_shift[3:0]  = digit;
  end

  // Press/release FSM with registered Valid/Err pulses and the entry register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      samp       <= '0;
      cnt        <= '0;
      bus.BCDOut <= '0;
      bus.Valid  <= 1'b0;
      bus.Err    <= 1'b0;
      bus.Entry  <= '0;
      bus.Count  <= '0;
    end else begin
      samp      <= bus.DECIn;
      cnt       <= cnt_nxt;
      bus.Valid <= 1'b0;
      bus.Err   <= 1'b0;

      // Clear only touches the entry; the accept path below is gated off when it is set.
      if (bus.Clear) begin
        bus.Entry <= '0;
        bus.Count <= '0;
      end

      case (state)
        IDLE: begin
          if (any_key) state <= DEB;
        end
        DEB: begin
          if (!any_key) begin
            state <= IDLE;
          end else if (reached) begin
            state <= HELD;
            if (one_hot && !locked) begin
              if (!bus.Clear) begin
                bus.Valid  <= 1'b1;
                bus.BCDOut <= digit;
                bus.Entry  <= entry_shift;
                if (!full) bus.Count <= bus.Count + 4'd1;
              end
            end else begin
              bus.Err <= 1'b1;
            end
          end
        end
        HELD: begin
          // Other key patterns while held are ignored: no rollover.
          if (!any_key) state <= REL;
        end
        REL: begin
          // A key reappearing during release is treated as bounce of the same press.
          if (any_key) begin
            state <= HELD;
          end else if (reached) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_to_bcd_key_encoder.sv
// Self-checking bench for dec_to_bcd_key_encoder: directed scenarios plus random presses vs. a press-event model.
// Latency: outputs are compared 1 time unit after every rising edge.
// Backpressure: none.
module tb_dec_to_bcd_key_encoder;

  localparam int DIGITS = 4;
  localparam int DEB    = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dec_to_bcd_key_encoder_if #(.DIGITS(DIGITS)) bus ();

  dec_to_bcd_key_encoder #(
    .DIGITS    (DIGITS),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  int ecnt     = 0;

  // Reference model: a run of identical samples of length DEB is a debounced event.
  // "armed" means the keypad has been released long enough for a new press to count.
  logic [9:0] m_prev;
  int         m_run;
  bit         m_armed;
  int         m_q[$];
  logic [3:0] m_bcd;
  logic       m_valid;
  logic       m_err;

  function automatic logic [4*DIGITS-1:0] m_entry();
    logic [4*DIGITS-1:0] e;
    e = '0;
    foreach (m_q[i]) e = (e << 4) | (4*DIGITS)'(m_q[i]);
    return e;
  endfunction

  task automatic model_reset();
    m_prev  = '0;
    m_run   = 0;
    m_armed = 1'b1;
    m_q.delete();
    m_bcd   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] dec, input logic clr);
    bit locked;
    int d;
    if (dec == m_prev) m_run++;
    else begin
      m_prev = dec;
      m_run  = 1;
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (m_armed && dec != 0 && m_run == DEB) begin
      m_armed = 1'b0;
      locked  = 1'b0;
`ifdef KEY_LOCK_EN
      locked  = (m_q.size() == DIGITS);
`endif
      if ($countones(dec) == 1 && !locked) begin
        if (!clr) begin
          d       = $clog2(dec);
          m_valid = 1'b1;
          m_bcd   = 4'(d);
          m_q.push_back(d);
          if (m_q.size() > DIGITS) void'(m_q.pop_front());
        end
      end else begin
        m_err = 1'b1;
      end
    end else if (!m_armed && dec == 0 && m_run == DEB) begin
      m_armed = 1'b1;
    end
    if (clr) m_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, step model on the edge, compare all outputs just after it.
  task automatic tick(input logic [9:0] dec, input logic clr);
    bus.DECIn = dec;
    bus.Clear = clr;
    @(posedge CLK);
    model_step(dec, clr);
    #1;
    chk("valid",  32'(bus.Valid),  32'(m_valid));
    chk("err",    32'(bus.Err),    32'(m_err));
    chk("bcdout", 32'(bus.BCDOut), 32'(m_bcd));
    chk("entry",  32'(bus.Entry),  32'(m_entry()));
    chk("count",  32'(bus.Count),  32'(m_q.size()));
    chk("valid_err_excl", 32'(bus.Valid & bus.Err), 32'd0);
    vcnt += int'(bus.Valid);
    ecnt += int'(bus.Err);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk("rst_bcdout", 32'(bus.BCDOut), 32'd0);
    chk("rst_valid",  32'(bus.Valid),  32'd0);
    chk("rst_err",    32'(bus.Err),    32'd0);
    chk("rst_entry",  32'(bus.Entry),  32'd0);
    chk("rst_count",  32'(bus.Count),  32'd0);
    #1 RST = 1'b0;
  endtask

  function automatic logic rclr();
    return ($urandom_range(0, 19) == 0);
  endfunction

  initial begin
    logic [9:0] dec;
    RST       = 1'b1;
    bus.DECIn = 10'h004;
    bus.Clear = 1'b0;
    model_reset();
    #12;
    chk("reset_bcdout", 32'(bus.BCDOut), 32'd0);
    chk("reset_valid",  32'(bus.Valid),  32'd0);
    chk("reset_err",    32'(bus.Err),    32'd0);
    chk("reset_entry",  32'(bus.Entry),  32'd0);
    chk("reset_count",  32'(bus.Count),  32'd0);
    RST = 1'b0;

    // First press of key 2 straight out of reset.
    vcnt = 0;
    repeat (6) tick(10'h004, 1'b0);
    chk("press2_valids", 32'(vcnt), 32'd1);
    chk("press2_bcd",    32'(bus.BCDOut), 32'd2);
    chk("press2_entry",  32'(bus.Entry),  32'h0002);
    chk("press2_count",  32'(bus.Count),  32'd1);
    repeat (6) tick(10'h000, 1'b0);

    // Bouncy press and bouncy release of key 3.
    vcnt = 0;
    repeat (3) begin
      tick(10'h008, 1'b0);
      tick(10'h000, 1'b0);
    end
    repeat (6) tick(10'h008, 1'b0);
    repeat (3) begin
      tick(10'h000, 1'b0);
      tick(10'h008, 1'b0);
    end
    repeat (6) tick(10'h000, 1'b0);
    chk("bounce_valids", 32'(vcnt), 32'd1);
    chk("bounce_bcd",    32'(bus.BCDOut), 32'd3);

    // Two keys at once are rejected and leave the entry alone.
    vcnt = 0;
    ecnt = 0;
    repeat (6) tick(10'h201, 1'b0);
    chk("multi_errs",   32'(ecnt), 32'd1);
    chk("multi_valids", 32'(vcnt), 32'd0);
    chk("multi_entry",  32'(bus.Entry), 32'h0023);
    chk("multi_count",  32'(bus.Count), 32'd2);
    repeat (6) tick(10'h000, 1'b0);

    // Keys 1..5 into a cleared 4-digit entry.
    tick(10'h000, 1'b1);
    ecnt = 0;
    for (int k = 1; k <= 5; k++) begin
      repeat (5) tick(10'h001 << k, 1'b0);
      repeat (5) tick(10'h000, 1'b0);
    end
`ifdef KEY_LOCK_EN
    chk("seq_entry", 32'(bus.Entry), 32'h1234);
    chk("seq_errs",  32'(ecnt), 32'd1);
`else
    chk("seq_entry", 32'(bus.Entry), 32'h2345);
    chk("seq_errs",  32'(ecnt), 32'd0);
`endif
    chk("seq_count", 32'(bus.Count), 32'd4);

    // Clear on the same edge that would accept key 7.
    repeat (3) tick(10'h080, 1'b0);
    tick(10'h080, 1'b1);
    chk("clrcol_valid", 32'(bus.Valid), 32'd0);
    chk("clrcol_entry", 32'(bus.Entry), 32'd0);
    chk("clrcol_count", 32'(bus.Count), 32'd0);
`ifdef KEY_LOCK_EN
    chk("clrcol_bcd", 32'(bus.BCDOut), 32'd4);
`else
    chk("clrcol_bcd", 32'(bus.BCDOut), 32'd5);
`endif
    repeat (3) tick(10'h080, 1'b0);
    repeat (5) tick(10'h000, 1'b0);

    // Reset while key 9 is held, then the same held key counts as a fresh press.
    repeat (6) tick(10'h200, 1'b0);
    async_reset();
    vcnt = 0;
    repeat (4) tick(10'h200, 1'b0);
    chk("rstheld_valids", 32'(vcnt), 32'd1);
    chk("rstheld_bcd",    32'(bus.BCDOut), 32'd9);
    chk("rstheld_entry",  32'(bus.Entry),  32'h0009);
    chk("rstheld_count",  32'(bus.Count),  32'd1);
    repeat (2) tick(10'h200, 1'b0);
    repeat (5) tick(10'h000, 1'b0);

    // Random presses with bounce, occasional extra keys, clears and resets.
    repeat (60) begin
      dec = 10'h001 << $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) dec = dec | (10'h001 << $urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) begin
        tick(dec, rclr());
        tick(10'h000, rclr());
      end
      repeat ($urandom_range(1, 8)) tick(dec, rclr());
      if ($urandom_range(0, 15) == 0) async_reset();
      repeat ($urandom_range(0, 2)) begin
        tick(10'h000, rclr());
        tick(dec, rclr());
      end
      repeat ($urandom_range(1, 7)) tick(10'h000, rclr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
